// File: rtl/uncached_req_agent_pkg.sv
// rtl/uncached_req_agent_pkg.sv - shared cache types for the uncached request agent
package uncached_req_agent_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int PHYS_WIDTH  = 32;
    localparam int BE_WIDTH    = DATA_WIDTH / 8;
    localparam int LABEL_WIDTH = PHYS_WIDTH - $clog2(BE_WIDTH);

    typedef logic [PHYS_WIDTH-1:0]  phys_t;
    typedef logic [BE_WIDTH-1:0]    be_t;
    typedef logic [LABEL_WIDTH-1:0] label_t;
    typedef logic [DATA_WIDTH-1:0]  data_t;

    typedef struct packed {
        logic   ls_type;
        be_t    be;
        label_t label;
        data_t  data;
    } line_t;

    localparam logic LS_LOAD  = 1'b1;
    localparam logic LS_STORE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } agent_state_t;

    function automatic label_t addr_label(input phys_t addr);
        return addr[PHYS_WIDTH-1 -: LABEL_WIDTH];
    endfunction

endpackage

// File: rtl/uncached_req_agent_if.sv
// rtl/uncached_req_agent_if.sv - pipeline and dcache_pass signals of the uncached request agent
interface uncached_req_agent_if;
    import uncached_req_agent_pkg::*;

    logic  req;
    logic  req_we;
    be_t   req_be;
    phys_t req_addr;
    data_t req_wdata;
    logic  flush;
    logic  stall;
    logic  rvalid;
    data_t rdata;
    logic  err;
    line_t pline;
    logic  push;
    logic  full;
    line_t rline;

    // master: the agent itself; slave: pipeline plus dcache_pass side
    modport master (
        input  req, req_we, req_be, req_addr, req_wdata, flush, full, rline,
        output stall, rvalid, rdata, err, pline, push
    );

    modport slave (
        output req, req_we, req_be, req_addr, req_wdata, flush, full, rline,
        input  stall, rvalid, rdata, err, pline, push
    );

endinterface

// File: rtl/uncached_req_agent.sv
// rtl/uncached_req_agent.sv - packs uncached loads/stores into dcache_pass lines, blocks on loads
module uncached_req_agent
    import uncached_req_agent_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    uncached_req_agent_if.master bus
);

    agent_state_t state, state_nxt;
    label_t       saved_label, saved_label_nxt;
    data_t        rdata_q, rdata_nxt;
    logic         rvalid_q, rvalid_nxt;
    logic         err_q, err_nxt;
    logic         push_c, stall_c;
    logic         resp_valid;
    line_t        line_c;
    logic         unused_bits;

    assign resp_valid  = bus.rline.ls_type;
    assign unused_bits = ^{bus.rline.be, bus.req_addr[1:0]};

    always_comb begin
        line_c.ls_type = bus.req_we ? LS_STORE : LS_LOAD;
        line_c.be      = bus.req_be;
        line_c.label   = addr_label(bus.req_addr);
        line_c.data    = bus.req_we ? bus.req_wdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            saved_label <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            saved_label <= saved_label_nxt;
            rdata_q     <= rdata_nxt;
            rvalid_q    <= rvalid_nxt;
            err_q       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        saved_label_nxt = saved_label;
        rdata_nxt       = rdata_q;
        rvalid_nxt      = 1'b0;
        err_nxt         = err_q;
        push_c          = 1'b0;
        stall_c         = 1'b0;

        case (state)
            ST_IDLE: begin
                push_c  = bus.req & ~bus.flush & ~bus.full;
                // a load stalls even while it is being pushed; a store only when blocked
                stall_c = bus.req & ~bus.flush & (bus.full | ~bus.req_we);
                if (push_c && !bus.req_we) begin
                    saved_label_nxt = line_c.label;
                    state_nxt       = ST_WAIT;
                end
                if (resp_valid) begin
                    err_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (bus.flush) begin
                    state_nxt = resp_valid ? ST_IDLE : ST_DRAIN;
                end else if (resp_valid) begin
                    rdata_nxt  = bus.rline.data;
                    rvalid_nxt = 1'b1;
                    state_nxt  = ST_RESP;
                    if (bus.rline.label != saved_label) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                if (resp_valid) begin
                    err_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                stall_c = bus.req;
                if (resp_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // while reset is held nothing may reach dcache_pass
        if (rst) begin
            push_c  = 1'b0;
            stall_c = bus.req & bus.full;
        end
    end

    assign bus.push   = push_c;
    assign bus.stall  = stall_c;
    assign bus.pline  = line_c;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

endmodule
